// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational ALU between two requesters, with registered response
// and architectural {n,z,c,v} status. Define ALU_SHARE_CARRY_SEQ_EN for two-pass ADC/SBC carry-in.
module alu_share_ctrl #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   reqValid,
    output logic [1:0]   reqReady,
    input  logic [N-1:0] reqA0,
    input  logic [N-1:0] reqB0,
    input  logic [N-1:0] reqA1,
    input  logic [N-1:0] reqB1,
    input  logic [3:0]   reqCmd0,
    input  logic [3:0]   reqCmd1,
    input  logic [1:0]   reqS,
    output logic [N-1:0] aluA,
    output logic [N-1:0] aluB,
    output logic [3:0]   aluCmd,
    input  logic [N-1:0] aluOut,
    input  logic [3:0]   aluStatus,
    output logic         rspValid,
    input  logic         rspReady,
    output logic         rspId,
    output logic [N-1:0] rspData,
    output logic [3:0]   rspStatus,
    output logic [3:0]   statusReg
);

`ifdef ALU_SHARE_CARRY_SEQ_EN
    localparam logic [3:0] CmdAdd = 4'b0010;
    localparam logic [3:0] CmdAdc = 4'b0011;
    localparam logic [3:0] CmdSub = 4'b0100;
    localparam logic [3:0] CmdSbc = 4'b0101;

    typedef enum logic [1:0] {StIdle, StResp, StPass2} state_e;
`else
    typedef enum logic [1:0] {StIdle, StResp} state_e;
`endif

    state_e       state_q;
    logic         last_grant_q;
    logic [N-1:0] drive_a_q;
    logic [N-1:0] drive_b_q;
    logic [3:0]   drive_cmd_q;

    logic         acc_open;
    logic         grant;
    logic         accept;
    logic [N-1:0] g_a;
    logic [N-1:0] g_b;
    logic [3:0]   g_cmd;
    logic         g_s;

    always_comb begin
        acc_open = !rst && ((state_q == StIdle) || ((state_q == StResp) && rspReady));
        grant    = (reqValid == 2'b11) ? !last_grant_q : reqValid[1];
        accept   = acc_open && (reqValid != 2'b00);
        reqReady = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
        g_a      = grant ? reqA1 : reqA0;
        g_b      = grant ? reqB1 : reqB0;
        g_cmd    = grant ? reqCmd1 : reqCmd0;
        g_s      = reqS[grant];
    end

    // Outside an accept the ALU keeps seeing the last driven operands, so aluOut stays stable.
    always_comb begin
        aluA   = accept ? g_a : drive_a_q;
        aluB   = accept ? g_b : drive_b_q;
        aluCmd = accept ? g_cmd : drive_cmd_q;
    end

`ifdef ALU_SHARE_CARRY_SEQ_EN
    logic       c1_q;
    logic       v1_q;
    logic       s_pend_q;
    logic       two_pass;
    logic [3:0] pass2_status;

    assign two_pass = ((g_cmd == CmdAdc) && statusReg[1]) || ((g_cmd == CmdSbc) && !statusReg[1]);
    assign pass2_status = {aluOut[N-1], ~|aluOut, c1_q | aluStatus[1], v1_q ^ aluStatus[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rspValid     <= 1'b0;
            rspId        <= 1'b0;
            rspData      <= '0;
            rspStatus    <= '0;
            statusReg    <= '0;
            last_grant_q <= 1'b1;
            drive_a_q    <= '0;
            drive_b_q    <= '0;
            drive_cmd_q  <= '0;
`ifdef ALU_SHARE_CARRY_SEQ_EN
            c1_q         <= 1'b0;
            v1_q         <= 1'b0;
            s_pend_q     <= 1'b0;
`endif
        end else if (accept) begin
            last_grant_q <= grant;
            rspId        <= grant;
            drive_a_q    <= g_a;
            drive_b_q    <= g_b;
            drive_cmd_q  <= g_cmd;
`ifdef ALU_SHARE_CARRY_SEQ_EN
            if (two_pass) begin
                // Second pass folds the carry-in as +1 (ADC) or -1 (SBC) on the first result.
                state_q     <= StPass2;
                rspValid    <= 1'b0;
                c1_q        <= aluStatus[1];
                v1_q        <= aluStatus[0];
                s_pend_q    <= g_s;
                drive_a_q   <= aluOut;
                drive_b_q   <= {{(N-1){1'b0}}, 1'b1};
                drive_cmd_q <= (g_cmd == CmdAdc) ? CmdAdd : CmdSub;
            end else
`endif
            begin
                state_q   <= StResp;
                rspValid  <= 1'b1;
                rspData   <= aluOut;
                rspStatus <= aluStatus;
                if (g_s) begin
                    statusReg <= aluStatus;
                end
            end
        end else begin
            case (state_q)
                StResp: begin
                    if (rspReady) begin
                        state_q  <= StIdle;
                        rspValid <= 1'b0;
                    end
                end
`ifdef ALU_SHARE_CARRY_SEQ_EN
                StPass2: begin
                    state_q   <= StResp;
                    rspValid  <= 1'b1;
                    rspData   <= aluOut;
                    rspStatus <= pass2_status;
                    if (s_pend_q) begin
                        statusReg <= pass2_status;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference of the arbitration/response rules. Honours ALU_SHARE_CARRY_SEQ_EN.
module tb_alu_share_ctrl;

    localparam logic [3:0] CMov = 4'b0001, CMvn = 4'b1001, CAdd = 4'b0010, CAdc = 4'b0011;
    localparam logic [3:0] CSub = 4'b0100, CSbc = 4'b0101, CAnd = 4'b0110, COrr = 4'b0111;
    localparam logic [3:0] CEor = 4'b1000, CBad = 4'b1111;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_s;
    logic [31:0] a0, b0, a1, b1, alu_a, alu_b, alu_out, rsp_data;
    logic [3:0]  cmd0, cmd1, alu_cmd, alu_status, rsp_status, status_reg;
    logic        rsp_valid, rsp_ready, rsp_id;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the controller should be holding, in spec terms.
    logic        m_pend, m_p2, m_last, m_id, m_p2s;
    logic [31:0] m_data, m_r1;
    logic [3:0]  m_st, m_sr, m_fin, m_p2cmd;

    always #5 clk = ~clk;

    alu_share_ctrl #(.N(32)) dut (
        .clk(clk), .rst(rst), .reqValid(req_valid), .reqReady(req_ready),
        .reqA0(a0), .reqB0(b0), .reqA1(a1), .reqB1(b1), .reqCmd0(cmd0), .reqCmd1(cmd1),
        .reqS(req_s), .aluA(alu_a), .aluB(alu_b), .aluCmd(alu_cmd), .aluOut(alu_out),
        .aluStatus(alu_status), .rspValid(rsp_valid), .rspReady(rsp_ready), .rspId(rsp_id),
        .rspData(rsp_data), .rspStatus(rsp_status), .statusReg(status_reg)
    );

    // Shared ALU model: no carry input, so ADC/SBC compute as ADD/SUB; c is carry / not-borrow.
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] cmd);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (cmd)
            CMov: r = b;
            CMvn: r = ~b;
            CAdd, CAdc: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            CSub, CSbc: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            CAnd: r = a & b;
            COrr: r = a | b;
            CEor: r = a ^ b;
            default: r = 32'h0;
        endcase
        return {r, r[31], (r == 32'h0), c, v};
    endfunction

    assign {alu_out, alu_status} = alu_fn(alu_a, alu_b, alu_cmd);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 1'b0; m_p2 = 1'b0; m_last = 1'b1; m_id = 1'b0; m_p2s = 1'b0;
        m_data = 32'h0; m_r1 = 32'h0; m_st = 4'h0; m_sr = 4'h0; m_fin = 4'h0; m_p2cmd = 4'h0;
    endtask

    // One clock: inputs are already driven; check combinational side, step model, check outputs.
    task automatic cycle();
        logic        open, g, acc, two;
        logic [1:0]  exp_rdy;
        logic [31:0] ga, gb;
        logic [3:0]  gc;
        logic [35:0] r1, r2;
        #1;
        open    = !m_p2 && (!m_pend || rsp_ready);
        g       = (req_valid == 2'b11) ? !m_last : req_valid[1];
        acc     = open && (req_valid != 2'b00);
        exp_rdy = acc ? (g ? 2'b10 : 2'b01) : 2'b00;
        ga      = g ? a1 : a0;
        gb      = g ? b1 : b0;
        gc      = g ? cmd1 : cmd0;
        chk("reqReady", 32'(req_ready), 32'(exp_rdy));
        if (acc) begin
            chk("aluA_grant", alu_a, ga);
            chk("aluCmd_grant", 32'(alu_cmd), 32'(gc));
        end
        if (m_p2) begin
            chk("aluA_pass2", alu_a, m_r1);
            chk("aluB_pass2", alu_b, 32'h1);
            chk("aluCmd_pass2", 32'(alu_cmd), 32'(m_p2cmd));
        end
        if (m_p2) begin
            m_p2 = 1'b0; m_pend = 1'b1; m_st = m_fin;
            if (m_p2s) m_sr = m_fin;
        end else if (acc) begin
            r1 = alu_fn(ga, gb, gc);
            m_last = g;
            m_id = g;
`ifdef ALU_SHARE_CARRY_SEQ_EN
            two = ((gc == CAdc) && m_sr[1]) || ((gc == CSbc) && !m_sr[1]);
`else
            two = 1'b0;
`endif
            if (two) begin
                m_p2cmd = (gc == CAdc) ? CAdd : CSub;
                m_r1 = r1[35:4];
                r2 = alu_fn(m_r1, 32'h1, m_p2cmd);
                m_data = r2[35:4];
                m_fin = {r2[35], (r2[35:4] == 32'h0), r1[1] | r2[1], r1[0] ^ r2[0]};
                m_p2s = req_s[g];
                m_p2 = 1'b1;
                m_pend = 1'b0;
            end else begin
                m_data = r1[35:4];
                m_st = r1[3:0];
                m_pend = 1'b1;
                if (req_s[g]) m_sr = r1[3:0];
            end
        end else if (m_pend && rsp_ready) begin
            m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("rspValid", 32'(rsp_valid), 32'(m_pend));
        if (m_pend) begin
            chk("rspData", rsp_data, m_data);
            chk("rspStatus", 32'(rsp_status), 32'(m_st));
            chk("rspId", 32'(rsp_id), 32'(m_id));
        end
        chk("statusReg", 32'(status_reg), 32'(m_sr));
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] cmd, input logic s);
        if (id == 0) begin
            a0 = a; b0 = b; cmd0 = cmd; req_s[0] = s; req_valid[0] = 1'b1;
        end else begin
            a1 = a; b1 = b; cmd1 = cmd; req_s[1] = s; req_valid[1] = 1'b1;
        end
    endtask

    logic [3:0] cmd_tab [10] = '{CMov, CMvn, CAdd, CAdc, CSub, CSbc, CAnd, COrr, CEor, CBad};

    function automatic logic [31:0] rnd_opnd();
        return ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom;
    endfunction

    initial begin
        rst = 1'b1; req_valid = 2'b11; req_s = 2'b00; rsp_ready = 1'b1;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; cmd0 = CAdd; cmd1 = CAdd;
        model_reset();
        @(posedge clk); #1;
        chk("reset_reqReady", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        chk("reset_rspValid", 32'(rsp_valid), 32'h0);
        chk("reset_rspData", rsp_data, 32'h0);
        chk("reset_rspStatus", 32'(rsp_status), 32'h0);
        chk("reset_rspId", 32'(rsp_id), 32'h0);
        chk("reset_statusReg", 32'(status_reg), 32'h0);
        rst = 1'b0; req_valid = 2'b00;

        // Single ADD on requester 0.
        set_req(0, 32'd5, 32'd7, CAdd, 1'b1);
        #1 chk("add_ready_same_cycle", 32'(req_ready), 32'h1);
        cycle();
        chk("add_data", rsp_data, 32'd12);
        chk("add_id", 32'(rsp_id), 32'h0);
        chk("add_statusReg", 32'(status_reg), 32'h0);
        req_valid = 2'b00;
        cycle();

        // Set statusReg to 1000, then SUB with S=0 must not touch it.
        set_req(0, 32'd0, 32'd1, CSub, 1'b1);
        cycle();
        chk("neg_statusReg", 32'(status_reg), 32'h8);
        set_req(0, 32'd3, 32'd3, CSub, 1'b0);
        cycle();
        chk("sub_z", 32'(rsp_status[2]), 32'h1);
        chk("sub_statusReg_kept", 32'(status_reg), 32'h8);
        req_valid = 2'b00;
        cycle();

        // Signed overflow.
        set_req(0, 32'h7FFF_FFFF, 32'h1, CAdd, 1'b1);
        cycle();
        chk("ovf_data", rsp_data, 32'h8000_0000);
        chk("ovf_status", 32'(rsp_status), 32'h9);
        req_valid = 2'b00;

        // Unknown command returns zero with only z set.
        set_req(1, 32'h1234, 32'h5678, CBad, 1'b0);
        cycle();
        chk("bad_status", 32'(rsp_status), 32'h4);
        req_valid = 2'b00;
        cycle();

        // Consumer stall: response must be held, nothing accepted.
        rsp_ready = 1'b0;
        set_req(0, 32'h0, 32'hDEAD_BEEF, CMov, 1'b0);
        cycle();
        req_valid = 2'b00;
        set_req(1, 32'd1, 32'd2, CAdd, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_ready", 32'(req_ready), 32'h0);
            chk("stall_data", rsp_data, 32'hDEAD_BEEF);
        end
        rsp_ready = 1'b1;
        #1 chk("release_ready", 32'(req_ready), 32'h2);
        cycle();
        chk("release_data", rsp_data, 32'd3);
        chk("release_id", 32'(rsp_id), 32'h1);

        // Both requesters valid: strict alternation starting with 0, one response per cycle.
        set_req(0, 32'd10, 32'd1, CAdd, 1'b0);
        set_req(1, 32'd20, 32'd2, CSub, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rr_id", 32'(rsp_id), 32'(i % 2));
            chk("rr_onehot", 32'($countones(req_ready) <= 1), 32'h1);
        end
        req_valid = 2'b00;
        cycle();

        // ADC with statusReg.c = 1.
        set_req(0, 32'hFFFF_FFFF, 32'h1, CAdd, 1'b1);
        cycle();
        chk("carry_set", 32'(status_reg[1]), 32'h1);
        set_req(0, 32'hFFFF_FFFF, 32'h0, CAdc, 1'b0);
        cycle();
        req_valid = 2'b00;
`ifdef ALU_SHARE_CARRY_SEQ_EN
        chk("adc_pass2_busy", 32'(rsp_valid), 32'h0);
        cycle();
        chk("adc2_data", rsp_data, 32'h0);
        chk("adc2_status", 32'(rsp_status), 32'h6);
`else
        chk("adc1_data", rsp_data, 32'hFFFF_FFFF);
`endif
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req_valid = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
            rsp_ready = ($urandom_range(3) != 0);
            a0 = rnd_opnd(); b0 = rnd_opnd(); a1 = rnd_opnd(); b1 = rnd_opnd();
            cmd0 = cmd_tab[$urandom_range(9)];
            cmd1 = cmd_tab[$urandom_range(9)];
            req_s = 2'($urandom_range(3));
            cycle();
        end

        // Reset with a response in flight drops it.
        rsp_ready = 1'b0;
        set_req(0, 32'd1, 32'd1, CAdd, 1'b1);
        cycle();
        rst = 1'b1;
        #1 chk("rst_mid_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 2'b00;
        model_reset();
        chk("rst_mid_rspValid", 32'(rsp_valid), 32'h0);
        chk("rst_mid_statusReg", 32'(status_reg), 32'h0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
